// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the frame transmit reader.
package frame_tx_pkg;
  localparam int IFG_DEFAULT = 12;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       eod;
  } buf_entry_t;
endpackage

// File: rtl/frame_tx_skid.sv
// Two-entry {data, eod} prefetch buffer between the packet FIFO and the TX handshake.
module frame_tx_skid
  import frame_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       eod_i,
  input  logic       pop_i,
  output logic [1:0] occ_o,
  output logic [7:0] head_data_o,
  output logic       head_eod_o
);
  buf_entry_t ent0_q, ent0_d, ent1_q, ent1_d, new_e;
  logic [1:0] occ_q, occ_d;

  assign new_e = {data_i, eod_i};

  // ent0 is always the head; a pop shifts ent1 forward.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = new_e;
        else               ent1_d = new_e;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = new_e;
        end else begin
          ent0_d = new_e;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o       = occ_q;
  assign head_data_o = ent0_q.data;
  assign head_eod_o  = ent0_q.eod;
endmodule

// File: rtl/frame_tx_reader.sv
// Drains committed frames from the packet FIFO to the TX MAC with an inter-frame gap.
// Define FRAME_TX_STATS_EN to add tx_frame_total / tx_byte_total counters.
module frame_tx_reader
  import frame_tx_pkg::*;
#(
  parameter int IFG_CYCLES  = IFG_DEFAULT,
  parameter int FRAME_CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  fifo_do,
  input  logic        fifo_eod,
  input  logic        fifo_empty,
  output logic        fifo_re,
  input  logic        frame_push,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        cnt_ovf,
  output logic        underrun
`ifdef FRAME_TX_STATS_EN
  ,
  output logic [31:0] tx_frame_total,
  output logic [31:0] tx_byte_total
`endif
);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [FRAME_CNT_W-1:0] CNT_MAX = '1;

  tx_state_e              state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   inflight_q, tx_valid_q, tx_valid_d;
  logic                   cnt_ovf_q, cnt_ovf_d, underrun_q, underrun_d;
  logic [1:0]             occ, occ_nxt;
  logic [7:0]             head_data;
  logic                   head_eod, pop, frame_done, cnt_nz;

  assign pop        = tx_valid_q & tx_ready;
  assign frame_done = pop & head_eod;
  assign cnt_nz     = (frame_cnt_q != '0);
  assign occ_nxt    = occ + {1'b0, inflight_q} - {1'b0, pop};
  // Gated by rst_n so the FIFO is not read while this block is held in reset.
  assign fifo_re    = rst_n & ~fifo_empty &
                      (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  frame_tx_skid u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .data_i     (fifo_do),
    .eod_i      (fifo_eod),
    .pop_i      (pop),
    .occ_o      (occ),
    .head_data_o(head_data),
    .head_eod_o (head_eod)
  );

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    cnt_ovf_d   = cnt_ovf_q;
    if (frame_push && !frame_done) begin
      if (frame_cnt_q == CNT_MAX) cnt_ovf_d = 1'b1;
      else                        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end else if (frame_done && !frame_push) begin
      frame_cnt_d = frame_cnt_q - FRAME_CNT_W'(1);
    end
  end

  // Start decisions look at next-cycle occupancy so the first byte is presented
  // the cycle after it lands in the buffer.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    underrun_d = underrun_q;
    case (state_q)
      IDLE: if (cnt_nz && occ_nxt != 2'd0) state_d = SEND;
      SEND: begin
        if (occ == 2'd0) underrun_d = 1'b1;
        if (frame_done) begin
          if (IFG_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GW'(IFG_CYCLES - 1);
          end else begin
            state_d = (frame_cnt_q > FRAME_CNT_W'(1) && occ_nxt != 2'd0) ? SEND : IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - GW'(1);
        else state_d = (cnt_nz && occ_nxt != 2'd0) ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid_d = (state_d == SEND) && (occ_nxt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      gap_q       <= '0;
      inflight_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      cnt_ovf_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      gap_q       <= gap_d;
      inflight_q  <= fifo_re;
      tx_valid_q  <= tx_valid_d;
      cnt_ovf_q   <= cnt_ovf_d;
      underrun_q  <= underrun_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = head_data;
  assign tx_last  = head_eod;
  assign cnt_ovf  = cnt_ovf_q;
  assign underrun = underrun_q;

`ifdef FRAME_TX_STATS_EN
  logic [31:0] frame_total_q, byte_total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_total_q <= '0;
      byte_total_q  <= '0;
    end else begin
      if (pop)        byte_total_q  <= byte_total_q + 32'd1;
      if (frame_done) frame_total_q <= frame_total_q + 32'd1;
    end
  end

  assign tx_frame_total = frame_total_q;
  assign tx_byte_total  = byte_total_q;
`endif
endmodule
